// File: rtl/sound_glu_rw_pkg.sv
// sound_glu_pkg: shared types, register offsets and reset constants for the IIgs sound GLU.
package sound_glu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RAM_WR, S_RAM_RD, S_DOC_RD} state_t;
  localparam logic [15:0] GLU_BASE = 16'hC03C;
  localparam logic [1:0] OFF_CTRL = 2'd0, OFF_DATA = 2'd1, OFF_PTRL = 2'd2, OFF_PTRH = 2'd3;
  localparam int CTRL_RAM = 6, CTRL_AINC = 5;
  localparam logic [6:0] CTRL_RST = 7'h0F, CTRL_WMASK = 7'h6F;
  localparam logic [7:0] SDATA_RST = 8'h00, SDATA_TOUT = 8'hFF;
  localparam logic [15:0] PTR_RST = 16'h0000;
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    return w[8*l +: 8];
  endfunction
endpackage

// File: rtl/sound_glu_rw_if.sv
// sound_glu_rw_if: req/ready SDRAM port between the GLU and the sound-RAM controller.
interface sound_glu_rw_if #(parameter int AW = 21);
  logic          ram_rd_o;
  logic          ram_wr_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_byte_en_o;
  logic [31:0]   ram_data_o;
  logic          ram_ready_i;
  logic [31:0]   ram_q_i;
  modport master(output ram_rd_o, ram_wr_o, ram_addr_o, ram_byte_en_o, ram_data_o, input ram_ready_i, ram_q_i);
  modport slave(input ram_rd_o, ram_wr_o, ram_addr_o, ram_byte_en_o, ram_data_o, output ram_ready_i, ram_q_i);
endinterface

// File: rtl/sound_glu_rw_ram_port.sv
// sound_glu_ram_port: holds one SDRAM request until ready or timeout and extracts the read lane.
module sound_glu_ram_port
  import sound_glu_pkg::*;
#(
  parameter int AW             = 21,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_logic,
  input  logic          system_reset_n,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_data,
  input  logic [1:0]    i_lane,
  output logic          o_done,
  output logic          o_timeout,
  output logic [7:0]    o_rdata,
  sound_glu_rw_if.master ram
);
  localparam int CW = TIMEOUT_CYCLES < 1 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic          r_rd, r_wr;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_data;
  logic [1:0]    r_lane;
  logic [CW-1:0] r_cnt;
  logic          w_req;
  assign w_req     = r_rd | r_wr;
  assign o_timeout = w_req & ~ram.ram_ready_i & (r_cnt == CW'(TIMEOUT_CYCLES));
  assign o_done    = w_req & (ram.ram_ready_i | o_timeout);
  assign o_rdata   = lane_byte(ram.ram_q_i, r_lane);
  always_ff @(posedge clk_logic or negedge system_reset_n)
    if (!system_reset_n) begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_be   <= '0;
      r_data <= '0;
      r_lane <= '0;
      r_cnt  <= '0;
    end else if (i_rd | i_wr) begin
      r_rd   <= i_rd;
      r_wr   <= i_wr;
      r_addr <= i_addr;
      r_be   <= i_be;
      r_data <= i_data;
      r_lane <= i_lane;
      r_cnt  <= '0;
    end else if (o_done) begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
    end else if (w_req) r_cnt <= r_cnt + 1'b1;
  assign ram.ram_rd_o      = r_rd;
  assign ram.ram_wr_o      = r_wr;
  assign ram.ram_addr_o    = r_addr;
  assign ram.ram_byte_en_o = r_be;
  assign ram.ram_data_o    = r_data;
endmodule

// File: rtl/sound_glu_rw.sv
// sound_glu_rw: Apple II bus front-end for the DOC5503 and its sound RAM, with read-back and prefetched data reads.
module sound_glu_rw
  import sound_glu_pkg::*;
#(
  parameter int ENABLE           = 1,
  parameter int READ_ENABLE      = 1,
  parameter int SDRAM_ADDR_WIDTH = 21,
  parameter logic [SDRAM_ADDR_WIDTH-1:0] SDRAM_BASE = 'h1_0000,
  parameter int DOC_READ_LATENCY = 2,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        phi0,
  input  logic        m2sel_n,
  input  logic        rw_n,
  input  logic        data_in_strobe,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic [7:0]  data_o,
  output logic        rd_en_o,
  sound_glu_rw_if.master ram,
  output logic        doc_cs_n_o,
  output logic        doc_we_n_o,
  output logic [7:0]  doc_addr_o,
  output logic [7:0]  doc_data_o,
  input  logic [7:0]  doc_data_i,
  output logic [3:0]  volume_o,
  output logic        overrun_o,
  output logic        timeout_o
);
  state_t r_state, w_next;
  logic [6:0]  r_ctrl;
  logic [7:0]  r_sdata, r_doc_addr, r_doc_data, w_rdata;
  logic [15:0] r_ptr;
  logic [2:0]  r_dcnt;
  logic r_overrun, r_timeout, r_doc_cs, r_doc_we;
  logic w_sel, w_acc, w_acc_data, w_busy, w_go, w_ram, w_ctrl_wr, w_done, w_tout, w_doc_done;
  logic [SDRAM_ADDR_WIDTH-1:0] w_ram_addr;
  logic [3:0] w_ram_be;
  assign w_sel      = (ENABLE != 0) & phi0 & ~m2sel_n & (addr[15:2] == GLU_BASE[15:2]);
  assign w_acc      = w_sel & data_in_strobe;
  assign w_acc_data = w_acc & (addr[1:0] == OFF_DATA);
  assign w_ctrl_wr  = w_acc & ~rw_n & (addr[1:0] == OFF_CTRL);
  assign w_busy     = r_state != S_IDLE;
  assign w_go       = w_acc_data & ~w_busy;
  assign w_ram      = r_ctrl[CTRL_RAM];
  assign w_doc_done = (r_state == S_DOC_RD) & (r_dcnt == 3'(DOC_READ_LATENCY - 1));
  assign w_ram_addr = SDRAM_BASE + SDRAM_ADDR_WIDTH'(r_ptr[15:2]);
  assign w_ram_be   = 4'b0001 << r_ptr[1:0];
  sound_glu_ram_port #(.AW(SDRAM_ADDR_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ram_port (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .i_rd           (w_go & rw_n & w_ram),
    .i_wr           (w_go & ~rw_n & w_ram),
    .i_addr         (w_ram_addr),
    .i_be           (w_ram_be),
    .i_data         ({4{data}}),
    .i_lane         (r_ptr[1:0]),
    .o_done         (w_done),
    .o_timeout      (w_tout),
    .o_rdata        (w_rdata),
    .ram            (ram)
  );
  always_ff @(posedge clk_logic or negedge system_reset_n)
    if (!system_reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = w_go ? (w_ram ? (rw_n ? S_RAM_RD : S_RAM_WR) : (rw_n ? S_DOC_RD : S_IDLE))
           : (w_done | w_doc_done) ? S_IDLE : r_state;
  always_comb begin
    data_o     = addr[1:0] == OFF_CTRL ? {w_busy, r_ctrl} : addr[1:0] == OFF_DATA ? r_sdata
               : addr[1:0] == OFF_PTRL ? r_ptr[7:0] : r_ptr[15:8];
    rd_en_o    = (READ_ENABLE != 0) & w_sel & rw_n;
    doc_cs_n_o = ~r_doc_cs;
    doc_we_n_o = ~r_doc_we;
    // the strobe carries the address latched at issue, since auto-increment has already moved ptr
    doc_addr_o = r_doc_cs ? r_doc_addr : r_ptr[7:0];
    doc_data_o = r_doc_data;
    volume_o   = r_ctrl[3:0];
    overrun_o  = r_overrun;
    timeout_o  = r_timeout;
  end
  always_ff @(posedge clk_logic or negedge system_reset_n)
    if (!system_reset_n) begin
      r_ctrl     <= CTRL_RST;
      r_sdata    <= SDATA_RST;
      r_ptr      <= PTR_RST;
      r_dcnt     <= '0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
      r_doc_cs   <= 1'b0;
      r_doc_we   <= 1'b0;
      r_doc_addr <= '0;
      r_doc_data <= '0;
    end else begin
      r_doc_cs <= w_go & ~w_ram;
      r_doc_we <= w_go & ~w_ram & ~rw_n;
      if (w_go & ~w_ram) r_doc_addr <= r_ptr[7:0];
      if (w_go & ~w_ram & ~rw_n) r_doc_data <= data;
      r_dcnt <= r_state == S_DOC_RD ? r_dcnt + 3'd1 : 3'd0;
      if (w_ctrl_wr) r_ctrl <= data[6:0] & CTRL_WMASK;
      if (w_acc & ~rw_n & (addr[1:0] == OFF_PTRL)) r_ptr[7:0] <= data;
      if (w_acc & ~rw_n & (addr[1:0] == OFF_PTRH)) r_ptr[15:8] <= data;
      if (w_go & r_ctrl[CTRL_AINC]) r_ptr <= r_ptr + 16'd1;
      if (w_go & w_ram & ~rw_n) r_sdata <= data;
      else if ((r_state == S_RAM_RD) & w_done) r_sdata <= w_tout ? SDATA_TOUT : w_rdata;
      else if (w_doc_done) r_sdata <= doc_data_i;
      r_overrun <= ~w_ctrl_wr & (r_overrun | (w_acc_data & w_busy));
      r_timeout <= ~w_ctrl_wr & (r_timeout | w_tout);
    end
endmodule

// File: tb/tb_sound_glu_rw.sv
// tb_sound_glu_rw: randomized scenario bench for sound_glu_rw against a register-level reference model.
module tb_sound_glu_rw;
  localparam int AW = 21;
  localparam logic [20:0] BASE = 21'h01_0000;
  localparam int TO = 255;
  localparam int LAT = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic phi0 = 1'b0, m2sel_n = 1'b1, rw_n = 1'b1, strobe = 1'b0;
  logic [15:0] addr = 16'hC03C;
  logic [7:0] data = 8'h00, doc_data_i = 8'h00;
  logic [7:0] data_o, doc_addr_o, doc_data_o;
  logic rd_en_o, doc_cs_n_o, doc_we_n_o, overrun_o, timeout_o;
  logic [3:0] volume_o;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [6:0] m_ctrl;
  logic [7:0] m_sdata;
  logic [15:0] m_ptr;
  sound_glu_rw_if #(.AW(AW)) ram_if ();
  sound_glu_rw #(.SDRAM_BASE(BASE), .DOC_READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
    .clk_logic(clk), .system_reset_n(rst_n), .phi0(phi0), .m2sel_n(m2sel_n), .rw_n(rw_n),
    .data_in_strobe(strobe), .addr(addr), .data(data), .data_o(data_o), .rd_en_o(rd_en_o),
    .ram(ram_if), .doc_cs_n_o(doc_cs_n_o), .doc_we_n_o(doc_we_n_o), .doc_addr_o(doc_addr_o),
    .doc_data_o(doc_data_o), .doc_data_i(doc_data_i), .volume_o(volume_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic bus(input logic [1:0] off, input logic is_wr, input logic [7:0] d, output logic [7:0] rd);
    @(negedge clk);
    addr = 16'hC03C | 16'(off); rw_n = ~is_wr; data = d; phi0 = 1'b1; m2sel_n = 1'b0; strobe = 1'b1;
    #1 rd = data_o;
    @(negedge clk);
    strobe = 1'b0; rw_n = 1'b1;
  endtask
  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    logic [7:0] junk;
    bus(off, 1'b1, d, junk);
    if (off == 2'd0) m_ctrl = d[6:0] & 7'h6F;
    if (off == 2'd2) m_ptr[7:0] = d;
    if (off == 2'd3) m_ptr[15:8] = d;
  endtask
  task automatic peek(input logic [1:0] off, output logic [7:0] v);
    addr = 16'hC03C | 16'(off); rw_n = 1'b1;
    #1 v = data_o;
  endtask
  task automatic set_ptr(input logic [15:0] p);
    wr(2'd2, p[7:0]);
    wr(2'd3, p[15:8]);
  endtask
  task automatic serve(input int k, input logic [31:0] q);
    repeat (k) @(negedge clk);
    ram_if.ram_ready_i = 1'b1; ram_if.ram_q_i = q;
    @(negedge clk);
    ram_if.ram_ready_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_ctrl = 7'h0F; m_sdata = 8'h00; m_ptr = 16'h0000;
    @(negedge clk);
    addr = 16'hC03C; rw_n = 1'b1; phi0 = 1'b1; m2sel_n = 1'b0;
    #1;
    n_checks++; if (data_o !== 8'h0F) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0f", data_o); end
    n_checks++; if (rd_en_o !== 1'b1) begin n_fail++; $display("FAIL reset_rd_en: got %b want 1", rd_en_o); end
    n_checks++; if ({ram_if.ram_rd_o, ram_if.ram_wr_o, doc_cs_n_o, doc_we_n_o} !== 4'b0011) begin n_fail++; $display("FAIL reset_req: got %b want 0011", {ram_if.ram_rd_o, ram_if.ram_wr_o, doc_cs_n_o, doc_we_n_o}); end
    n_checks++; if ({volume_o, overrun_o, timeout_o} !== 6'b111100) begin n_fail++; $display("FAIL reset_flags: got %b want 111100", {volume_o, overrun_o, timeout_o}); end
    phi0 = 1'b0;
    #1;
    n_checks++; if (rd_en_o !== 1'b0) begin n_fail++; $display("FAIL decode_phi0: got %b want 0", rd_en_o); end
    phi0 = 1'b1; m2sel_n = 1'b1; addr = 16'hC040;
    #1;
    n_checks++; if (rd_en_o !== 1'b0) begin n_fail++; $display("FAIL decode_addr: got %b want 0", rd_en_o); end
    m2sel_n = 1'b0;
  endtask
  task automatic test_ram_write;
    logic [7:0] d, v, lo, hi;
    logic [20:0] ea;
    logic [3:0] eb;
    logic [15:0] p;
    wr(2'd0, 8'h60);
    set_ptr(16'h12FF);
    for (int i = 0; i < 8; i++) begin
      if (i < 2) d = (i == 0) ? 8'hAA : 8'h55;
      else begin
        p = 16'($urandom); set_ptr(p); d = 8'($urandom);
      end
      ea = BASE + 21'(m_ptr / 4);
      eb = 4'(1 << (m_ptr % 4));
      bus(2'd1, 1'b1, d, v);
      m_sdata = d; m_ptr = m_ptr + 16'd1;
      n_checks++; if ({ram_if.ram_wr_o, ram_if.ram_rd_o} !== 2'b10) begin n_fail++; $display("FAIL wr_req[%0d]: got %b want 10", i, {ram_if.ram_wr_o, ram_if.ram_rd_o}); end
      n_checks++; if (ram_if.ram_addr_o !== ea || ram_if.ram_byte_en_o !== eb) begin n_fail++; $display("FAIL wr_addr[%0d]: got %h/%b want %h/%b", i, ram_if.ram_addr_o, ram_if.ram_byte_en_o, ea, eb); end
      n_checks++; if (ram_if.ram_data_o !== {d, d, d, d}) begin n_fail++; $display("FAIL wr_data[%0d]: got %h want %h", i, ram_if.ram_data_o, {d, d, d, d}); end
      repeat (2) @(negedge clk);
      n_checks++; if (ram_if.ram_wr_o !== 1'b1 || ram_if.ram_addr_o !== ea) begin n_fail++; $display("FAIL wr_hold[%0d]: got %b/%h want 1/%h", i, ram_if.ram_wr_o, ram_if.ram_addr_o, ea); end
      serve(0, 32'h0);
      n_checks++; if (ram_if.ram_wr_o !== 1'b0) begin n_fail++; $display("FAIL wr_drop[%0d]: got %b want 0", i, ram_if.ram_wr_o); end
      peek(2'd0, v);
      n_checks++; if (v !== {1'b0, m_ctrl}) begin n_fail++; $display("FAIL wr_idle[%0d]: got %h want %h", i, v, {1'b0, m_ctrl}); end
      peek(2'd1, v);
      n_checks++; if (v !== m_sdata) begin n_fail++; $display("FAIL wr_sdata[%0d]: got %h want %h", i, v, m_sdata); end
      if (i == 1) begin
        peek(2'd2, lo); peek(2'd3, hi);
        n_checks++; if ({hi, lo} !== 16'h1301) begin n_fail++; $display("FAIL wr_ptr: got %h want 1301", {hi, lo}); end
      end
    end
  endtask
  task automatic test_ram_read;
    logic [7:0] v, lo, hi, want;
    logic [31:0] q;
    logic [20:0] ea;
    wr(2'd0, 8'h60);
    set_ptr(16'h0001);
    q = 32'h44332211;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin set_ptr(16'($urandom)); q = $urandom; end
      ea = BASE + 21'(m_ptr / 4);
      want = 8'((q >> (8 * (m_ptr % 4))) & 32'hFF);
      bus(2'd1, 1'b0, 8'h00, v);
      n_checks++; if (v !== m_sdata) begin n_fail++; $display("FAIL rd_behind[%0d]: got %h want %h", i, v, m_sdata); end
      m_ptr = m_ptr + 16'd1;
      n_checks++; if ({ram_if.ram_rd_o, ram_if.ram_wr_o} !== 2'b10 || ram_if.ram_addr_o !== ea) begin n_fail++; $display("FAIL rd_req[%0d]: got %b/%h want 10/%h", i, {ram_if.ram_rd_o, ram_if.ram_wr_o}, ram_if.ram_addr_o, ea); end
      peek(2'd0, v);
      n_checks++; if (v !== {1'b1, m_ctrl}) begin n_fail++; $display("FAIL rd_busy[%0d]: got %h want %h", i, v, {1'b1, m_ctrl}); end
      serve(2, q);
      m_sdata = want;
      peek(2'd1, v);
      n_checks++; if (v !== want || ram_if.ram_rd_o !== 1'b0) begin n_fail++; $display("FAIL rd_data[%0d]: got %h/%b want %h/0", i, v, ram_if.ram_rd_o, want); end
      if (i == 1) begin
        peek(2'd2, lo); peek(2'd3, hi);
        n_checks++; if ({hi, lo} !== 16'h0003 || want !== 8'h33) begin n_fail++; $display("FAIL rd_ptr: got %h want 0003", {hi, lo}); end
      end
    end
  endtask
  task automatic test_doc;
    logic [7:0] v, ea, old, d;
    wr(2'd0, 8'h20);
    wr(2'd2, 8'hE0);
    doc_data_i = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin wr(2'd2, 8'($urandom)); doc_data_i = 8'($urandom); end
      ea = m_ptr[7:0]; old = m_sdata;
      bus(2'd1, 1'b0, 8'h00, v);
      m_ptr = m_ptr + 16'd1;
      n_checks++; if (v !== old) begin n_fail++; $display("FAIL doc_behind[%0d]: got %h want %h", i, v, old); end
      n_checks++; if ({doc_cs_n_o, doc_we_n_o} !== 2'b01 || doc_addr_o !== ea || ram_if.ram_rd_o !== 1'b0) begin n_fail++; $display("FAIL doc_strobe[%0d]: got %b/%h want 01/%h", i, {doc_cs_n_o, doc_we_n_o}, doc_addr_o, ea); end
      @(negedge clk);
      peek(2'd1, v);
      n_checks++; if (doc_cs_n_o !== 1'b1 || v !== old) begin n_fail++; $display("FAIL doc_early[%0d]: got %b/%h want 1/%h", i, doc_cs_n_o, v, old); end
      @(negedge clk);
      m_sdata = doc_data_i;
      peek(2'd1, v);
      n_checks++; if (v !== m_sdata) begin n_fail++; $display("FAIL doc_data[%0d]: got %h want %h", i, v, m_sdata); end
      peek(2'd2, v);
      n_checks++; if (v !== m_ptr[7:0]) begin n_fail++; $display("FAIL doc_ptr[%0d]: got %h want %h", i, v, m_ptr[7:0]); end
    end
    ea = m_ptr[7:0]; d = 8'($urandom);
    bus(2'd1, 1'b1, d, v);
    m_ptr = m_ptr + 16'd1;
    n_checks++; if ({doc_cs_n_o, doc_we_n_o} !== 2'b00 || doc_data_o !== d || doc_addr_o !== ea) begin n_fail++; $display("FAIL doc_write: got %b/%h/%h want 00/%h/%h", {doc_cs_n_o, doc_we_n_o}, doc_data_o, doc_addr_o, d, ea); end
    @(negedge clk);
    peek(2'd0, v);
    n_checks++; if ({doc_cs_n_o, doc_we_n_o} !== 2'b11 || v !== {1'b0, m_ctrl}) begin n_fail++; $display("FAIL doc_write_end: got %b/%h want 11/%h", {doc_cs_n_o, doc_we_n_o}, v, {1'b0, m_ctrl}); end
  endtask
  task automatic test_timeout;
    logic [7:0] v, lo, hi, x;
    logic [20:0] ea;
    int c1, n;
    wr(2'd0, 8'h60);
    set_ptr(16'($urandom));
    ea = BASE + 21'(m_ptr / 4);
    bus(2'd1, 1'b0, 8'h00, v);
    c1 = cyc;
    m_ptr = m_ptr + 16'd1;
    peek(2'd0, v);
    n_checks++; if (v[7] !== 1'b1) begin n_fail++; $display("FAIL to_busy: got %b want 1", v[7]); end
    bus(2'd1, 1'b1, 8'($urandom), v);
    peek(2'd2, lo); peek(2'd3, hi);
    n_checks++; if (overrun_o !== 1'b1 || {hi, lo} !== m_ptr) begin n_fail++; $display("FAIL overrun: got %b/%h want 1/%h", overrun_o, {hi, lo}, m_ptr); end
    n_checks++; if ({ram_if.ram_rd_o, ram_if.ram_wr_o} !== 2'b10 || ram_if.ram_addr_o !== ea) begin n_fail++; $display("FAIL overrun_req: got %b/%h want 10/%h", {ram_if.ram_rd_o, ram_if.ram_wr_o}, ram_if.ram_addr_o, ea); end
    x = 8'($urandom);
    wr(2'd2, x);
    peek(2'd2, lo);
    n_checks++; if (lo !== x || ram_if.ram_addr_o !== ea) begin n_fail++; $display("FAIL busy_ptr_wr: got %h/%h want %h/%h", lo, ram_if.ram_addr_o, x, ea); end
    n = 0;
    while (ram_if.ram_rd_o === 1'b1 && n < 2 * TO) begin @(negedge clk); n++; end
    n_checks++; if (ram_if.ram_rd_o !== 1'b0) begin n_fail++; $display("FAIL to_expire: got %b want 0 within %0d", ram_if.ram_rd_o, 2 * TO); end
    n_checks++; if (cyc - c1 < TO || cyc - c1 > TO + 2) begin n_fail++; $display("FAIL to_len: got %0d want %0d..%0d", cyc - c1, TO, TO + 2); end
    m_sdata = 8'hFF;
    peek(2'd1, v);
    n_checks++; if (v !== 8'hFF || timeout_o !== 1'b1 || overrun_o !== 1'b1) begin n_fail++; $display("FAIL to_data: got %h/%b/%b want ff/1/1", v, timeout_o, overrun_o); end
    peek(2'd0, v);
    n_checks++; if (v[7] !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b want 0", v[7]); end
    serve(0, 32'h12345678);
    peek(2'd1, v);
    n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL stale_ready: got %h want ff", v); end
    wr(2'd0, 8'h60);
    n_checks++; if ({overrun_o, timeout_o} !== 2'b00) begin n_fail++; $display("FAIL flag_clear: got %b want 00", {overrun_o, timeout_o}); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] v, lo, hi;
    wr(2'd0, 8'h60);
    set_ptr(16'($urandom));
    bus(2'd1, 1'b1, 8'($urandom), v);
    n_checks++; if (ram_if.ram_wr_o !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", ram_if.ram_wr_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({ram_if.ram_wr_o, ram_if.ram_rd_o, doc_cs_n_o, doc_we_n_o} !== 4'b0011) begin n_fail++; $display("FAIL mid_async: got %b want 0011", {ram_if.ram_wr_o, ram_if.ram_rd_o, doc_cs_n_o, doc_we_n_o}); end
    peek(2'd0, v);
    n_checks++; if (v !== 8'h0F) begin n_fail++; $display("FAIL mid_ctrl: got %h want 0f", v); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ctrl = 7'h0F; m_sdata = 8'h00; m_ptr = 16'h0000;
    serve(1, 32'hDEADBEEF);
    peek(2'd2, lo); peek(2'd3, hi);
    n_checks++; if ({hi, lo} !== m_ptr || ram_if.ram_wr_o !== 1'b0) begin n_fail++; $display("FAIL mid_ptr: got %h/%b want %h/0", {hi, lo}, ram_if.ram_wr_o, m_ptr); end
    peek(2'd1, v);
    n_checks++; if (v !== m_sdata) begin n_fail++; $display("FAIL mid_sdata: got %h want %h", v, m_sdata); end
    peek(2'd0, v);
    n_checks++; if (v !== {1'b0, m_ctrl}) begin n_fail++; $display("FAIL mid_idle: got %h want %h", v, {1'b0, m_ctrl}); end
  endtask
  initial begin
    ram_if.ram_ready_i = 1'b0;
    ram_if.ram_q_i = 32'h0;
    test_reset;
    test_ram_write;
    test_ram_read;
    test_doc;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
